cmsdk_mcu_pin_in_filter: RTL and testbench
==========================================

# cmsdk_mcu_pin_in_filter

Input-side conditioning for the MCU pin multiplexer. Takes raw pad input values (`p1_in` from the pads, asynchronous to the system clock), synchronises them, and removes glitches with a per-pin programmable stability filter. Produces clean level outputs and single-cycle rise/fall pulses. These feed `uart*_rxd`, `timer*_extin` and GPIO edge-interrupt logic. Sits between the pad IOBUF outputs and the peripheral inputs.

## Interface
- `WIDTH`, 16: number of pins filtered.
- `SYNC_STAGES`, 2: synchroniser flops per pin, minimum 2.
- `CNT_W`, 4: width of the filter length and of the per-pin counter.

- `HCLK` input 1: system clock. Single clock domain.
- `HRESET` input 1: reset, asynchronous, active-high.
- `pad_in` input WIDTH: raw pad input values, asynchronous.
- `filt_en` input WIDTH: per-pin filter enable. 0 means bypass (equivalent to length 1).
- `filt_len` input CNT_W: number of consecutive stable cycles required before a change is accepted. 0 is treated as 1.
- `filt_out` output WIDTH: filtered level.
- `rise_pulse` output WIDTH: one-cycle pulse on an accepted 0→1 change.
- `fall_pulse` output WIDTH: one-cycle pulse on an accepted 1→0 change.

## Operation
- Reset values, applied asynchronously while `HRESET`=1:
  - all synchroniser flops = 1, matching the pad pull-ups;
  - `filt_out` = all ones;
  - all counters = 0;
  - `rise_pulse` = 0 and `fall_pulse` = 0.
- Per pin i, with `s` = last synchroniser stage and `L` = effective length:
  - `L` = 1 if `filt_en[i]`=0 or `filt_len`=0; otherwise `L` = `filt_len`.
- Per-pin states: IDLE (`s`==`filt_out[i]`, cnt=0) and PEND (`s`!=`filt_out[i]`, counting).
  - IDLE, `s` equal: stay, cnt=0.
  - IDLE, `s` differs: if `L`==1, update `filt_out[i]` to `s` this edge. Otherwise cnt←1, go to PEND.
  - PEND, `s` differs and cnt ≥ `L`−1: update `filt_out[i]`, cnt←0, go to IDLE.
  - PEND, `s` differs and cnt < `L`−1: cnt←cnt+1.
  - PEND, `s` returns equal to `filt_out[i]`: treat as a glitch. cnt←0, go to IDLE, no output change.
- Counter width is CNT_W. The ≥ comparison guarantees no wrap: cnt never exceeds `L`−1.
- `filt_len` and `filt_en` are sampled live every cycle.
  - A mid-count change uses the new `L` on the next edge.
  - If the new `L`−1 ≤ current cnt, the update happens on the next cycle in which `s` still differs.
- Pulses:
  - `rise_pulse[i]`/`fall_pulse[i]` are registered together with the `filt_out[i]` update.
  - A pulse is high exactly in the first cycle the new level is visible, then 0.
  - Rise and fall are never both high on the same pin.
- Pins are fully independent. `filt_len` is shared by all pins.

## Timing
- Pad change to `s`: SYNC_STAGES edges (plus up to one cycle of sampling uncertainty).
- `s` differing to `filt_out` change: `L` edges.
- Total latency from a pad change aligned to an edge: SYNC_STAGES + `L` cycles. Bypass with default parameters gives 3 cycles.
- Minimum accepted pulse width on the pad: `L` cycles. Shorter pulses produce no output change and no pulse.
- Maximum toggle rate of `filt_out` per pin: once per `L` cycles.
- Reset deassertion mid-count: all counts are lost and the pin restarts in IDLE with level 1. A pad held at 0 through reset produces `fall_pulse` SYNC_STAGES + `L` cycles after release.
- No combinational path from any input to any output.

## Test plan
- Reset: hold `pad_in`=0x0000 while asserting `HRESET`.
  - During reset: `filt_out`=0xFFFF, pulses 0.
  - After release with `filt_len`=0, `filt_en`=0: `filt_out`=0x0000 at cycle 3 and `fall_pulse`=0xFFFF for exactly that one cycle.
- Filter accept: `filt_en[0]`=1, `filt_len`=5, `pad_in[0]` 1→0 and held.
  - `filt_out[0]` falls at cycle 2+5=7 after the edge.
  - `fall_pulse[0]` is high for one cycle at cycle 7.
- Glitch reject: same setup, `pad_in[0]` low for 4 cycles, then high.
  - `filt_out[0]` stays 1, no pulses.
  - A following 5-cycle low pulse is accepted, then its return to 1 is accepted 5 cycles later.
- Mid-count length change: `filt_len`=10, pin low 3 cycles after sync, then `filt_len`←2 with the pin held low.
  - `filt_out` falls on the next edge, since cnt ≥ 1.
- Independence: toggle pin 3 with `filt_en[3]`=0 and pin 4 with `filt_en[4]`=1, `filt_len`=8, on the same edge.
  - Pin 3 changes at cycle 3, pin 4 at cycle 10.
  - All other pins are unchanged.
- Reset mid-count: pin low 3 cycles into an 8-cycle filter, then pulse `HRESET`.
  - Output is 1 asynchronously, cnt=0.
  - After release the count restarts from 0, giving a fall 10 cycles after release.

Source files
------------

// File: rtl/cmsdk_mcu_pin_in_filter.sv
// rtl/cmsdk_mcu_pin_in_filter.sv - pad input synchroniser with per-pin stability filter and edge pulses
module cmsdk_mcu_pin_in_filter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic [WIDTH-1:0] pad_in,
    input  logic [WIDTH-1:0] filt_en,
    input  logic [CNT_W-1:0] filt_len,
    output logic [WIDTH-1:0] filt_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    typedef enum logic {IDLE, PEND} state_t;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];
    logic [CNT_W-1:0] pin_lm1 [WIDTH];
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] diff;
    logic [CNT_W-1:0] len_m1;

    // Synchroniser resets to 1 so released pads read as pulled-up.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '1;
            end
        end else begin
            sync_q[0] <= pad_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s      = sync_q[SYNC_STAGES-1];
    assign diff   = s ^ out_q;
    assign len_m1 = (filt_len == '0) ? '0 : filt_len - CNT_W'(1);

    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            pin_lm1[i] = filt_en[i] ? len_m1 : '0;
            if (!diff[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else if ((state_q[i] == IDLE && pin_lm1[i] == '0) ||
                         (state_q[i] == PEND && cnt_q[i] >= pin_lm1[i])) begin
                out_d[i]   = s[i];
                rise_d[i]  = s[i];
                fall_d[i]  = ~s[i];
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else if (state_q[i] == IDLE) begin
                state_d[i] = PEND;
                cnt_d[i]   = CNT_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            out_q  <= '1;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign filt_out   = out_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_cmsdk_mcu_pin_in_filter.sv
// tb/tb_cmsdk_mcu_pin_in_filter.sv - directed self-checking bench for cmsdk_mcu_pin_in_filter
module tb_cmsdk_mcu_pin_in_filter;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [15:0] pad_in;
    logic [15:0] filt_en;
    logic [3:0]  filt_len;
    logic [15:0] filt_out;
    logic [15:0] rise_pulse;
    logic [15:0] fall_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 HCLK = ~HCLK;

    cmsdk_mcu_pin_in_filter #(
        .WIDTH       (16),
        .SYNC_STAGES (2),
        .CNT_W       (4)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .pad_in     (pad_in),
        .filt_en    (filt_en),
        .filt_len   (filt_len),
        .filt_out   (filt_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got out/rise/fall=%h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic expect_io(input string tag, input logic [15:0] o, input logic [15:0] r,
                             input logic [15:0] f);
        check(tag, {filt_out, rise_pulse, fall_pulse}, {o, r, f});
    endtask

    initial begin
        HRESET   = 1'b1;
        pad_in   = 16'h0000;
        filt_en  = 16'h0000;
        filt_len = 4'd0;

        // reset with pads held low, bypass
        tick(2);
        expect_io("rst_hold", 16'hFFFF, 16'h0000, 16'h0000);
        HRESET = 1'b0;
        tick(2);
        expect_io("rst_c2", 16'hFFFF, 16'h0000, 16'h0000);
        tick(1);
        expect_io("rst_c3", 16'h0000, 16'h0000, 16'hFFFF);
        tick(1);
        expect_io("rst_c4", 16'h0000, 16'h0000, 16'h0000);
        pad_in = 16'hFFFF;
        tick(3);
        expect_io("rise_all", 16'hFFFF, 16'hFFFF, 16'h0000);
        tick(1);

        // filter accept, L=5
        filt_en  = 16'h0001;
        filt_len = 4'd5;
        pad_in   = 16'hFFFE;
        tick(6);
        expect_io("acc_c6", 16'hFFFF, 16'h0000, 16'h0000);
        tick(1);
        expect_io("acc_c7", 16'hFFFE, 16'h0000, 16'h0001);
        tick(1);
        expect_io("acc_c8", 16'hFFFE, 16'h0000, 16'h0000);
        pad_in = 16'hFFFF;
        tick(7);
        expect_io("acc_rise", 16'hFFFF, 16'h0001, 16'h0000);
        tick(2);

        // 4-cycle glitch rejected
        pad_in = 16'hFFFE;
        tick(4);
        pad_in = 16'hFFFF;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            expect_io("glitch", 16'hFFFF, 16'h0000, 16'h0000);
        end

        // 5-cycle pulse accepted both ways
        pad_in = 16'hFFFE;
        tick(5);
        pad_in = 16'hFFFF;
        tick(1);
        expect_io("p5_c6", 16'hFFFF, 16'h0000, 16'h0000);
        tick(1);
        expect_io("p5_c7", 16'hFFFE, 16'h0000, 16'h0001);
        tick(4);
        expect_io("p5_c11", 16'hFFFE, 16'h0000, 16'h0000);
        tick(1);
        expect_io("p5_c12", 16'hFFFF, 16'h0001, 16'h0000);
        tick(1);
        expect_io("p5_c13", 16'hFFFF, 16'h0000, 16'h0000);

        // length shrinks mid-count
        filt_len = 4'd10;
        pad_in   = 16'hFFFE;
        tick(5);
        expect_io("mid_c5", 16'hFFFF, 16'h0000, 16'h0000);
        filt_len = 4'd2;
        tick(1);
        expect_io("mid_c6", 16'hFFFE, 16'h0000, 16'h0001);
        pad_in = 16'hFFFF;
        tick(3);
        expect_io("mid_r3", 16'hFFFE, 16'h0000, 16'h0000);
        tick(1);
        expect_io("mid_r4", 16'hFFFF, 16'h0001, 16'h0000);
        tick(2);

        // pin 3 bypass, pin 4 filtered L=8
        filt_en  = 16'h0010;
        filt_len = 4'd8;
        pad_in   = 16'hFFE7;
        tick(2);
        expect_io("ind_c2", 16'hFFFF, 16'h0000, 16'h0000);
        tick(1);
        expect_io("ind_c3", 16'hFFF7, 16'h0000, 16'h0008);
        tick(6);
        expect_io("ind_c9", 16'hFFF7, 16'h0000, 16'h0000);
        tick(1);
        expect_io("ind_c10", 16'hFFE7, 16'h0000, 16'h0010);
        pad_in = 16'hFFFF;
        tick(12);
        expect_io("ind_back", 16'hFFFF, 16'h0000, 16'h0000);

        // reset mid-count: pin 0 filtered L=8, pin 5 bypass
        filt_en  = 16'h0001;
        filt_len = 4'd8;
        pad_in   = 16'hFFDE;
        tick(3);
        expect_io("rmc_c3", 16'hFFDF, 16'h0000, 16'h0020);
        tick(2);
        expect_io("rmc_c5", 16'hFFDF, 16'h0000, 16'h0000);
        HRESET = 1'b1;
        #2;
        expect_io("rmc_async", 16'hFFFF, 16'h0000, 16'h0000);
        tick(2);
        HRESET = 1'b0;
        tick(2);
        expect_io("rmc_r2", 16'hFFFF, 16'h0000, 16'h0000);
        tick(1);
        expect_io("rmc_r3", 16'hFFDF, 16'h0000, 16'h0020);
        tick(6);
        expect_io("rmc_r9", 16'hFFDF, 16'h0000, 16'h0000);
        tick(1);
        expect_io("rmc_r10", 16'hFFDE, 16'h0000, 16'h0001);
        tick(1);
        expect_io("rmc_r11", 16'hFFDE, 16'h0000, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
